// File: rtl/dvi_pkg.sv
// dvi_pkg: shared types and constants for the DVI timing controller and the
// TMDS encoders it feeds (axis region enum, ctrl pair type, colour bars).
package dvi_pkg;

  // Order on each axis: visible, front porch, sync, back porch.
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } dvi_region_e;

  // {vsync, hsync} levels as seen by the blue-channel TMDS encoder.
  typedef logic [1:0] dvi_ctrl_t;

  localparam int unsigned NUM_BARS = 8;

  // {r,g,b} colour-bar constants, left to right across the active line.
  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/dvi_axis_counter.sv
// dvi_axis_counter: one raster axis (horizontal or vertical). Counts
// 0..TOTAL-1 on inc_i, wraps to 0, and decodes the current region.
// clr_i has priority and holds the count at 0.
module dvi_axis_counter
  import dvi_pkg::*;
#(
  parameter int unsigned SEG_ACTIVE = 640,
  parameter int unsigned SEG_FRONT  = 16,
  parameter int unsigned SEG_SYNC   = 96,
  parameter int unsigned SEG_BACK   = 48,
  parameter int unsigned CNT_W      = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output dvi_region_e      region_o
);

  localparam int unsigned TOTAL = SEG_ACTIVE + SEG_FRONT + SEG_SYNC + SEG_BACK;

  localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(SEG_ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(SEG_ACTIVE + SEG_FRONT);
  localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(SEG_ACTIVE + SEG_FRONT + SEG_SYNC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear, hold, increment or wrap.
  always_comb begin
    wrap_o = inc_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Region decode from the current count.
  always_comb begin
    if (cnt_q < FRONT_START) begin
      region_o = ACTIVE;
    end else if (cnt_q < SYNC_START) begin
      region_o = FRONT;
    end else if (cnt_q < BACK_START) begin
      region_o = SYNC;
    end else begin
      region_o = BACK;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dvi_timing_ctrl.sv
// dvi_timing_ctrl: raster timing generator with a pixel fetch interface.
// Cycle n: counters -> registered request (pix_req, x, y, frame_start).
// Cycle n+1: pix_rgb returned by the source. Cycle n+2: registered
// disp_en, red/grn/blu and ctrl_b, so sync and data stay aligned.
// Optional build macro DVI_TEST_PATTERN_EN adds pattern_sel, selecting an
// internal 8-bar colour pattern in place of pix_rgb.
module dvi_timing_ctrl
  import dvi_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic        HSYNC_POL = 1'b0,
  parameter logic        VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        pix_req,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        frame_start,
  input  logic [23:0] pix_rgb,
  output logic        disp_en,
  output logic [1:0]  ctrl_b,
  output logic [7:0]  red,
  output logic [7:0]  grn,
  output logic [7:0]  blu
`ifdef DVI_TEST_PATTERN_EN
  ,
  input  logic        pattern_sel
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 2048) begin : g_chk_total
    $error("dvi_timing_ctrl: H_TOTAL must be <= 4096 and V_TOTAL <= 2048");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_chk_zero
    $error("dvi_timing_ctrl: timing parameters must be non-zero");
  end

  localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam dvi_ctrl_t   CTRL_IDLE = {~VSYNC_POL, ~HSYNC_POL};

  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_wrap, v_wrap;
  dvi_region_e h_region, v_region;

  dvi_axis_counter #(
    .SEG_ACTIVE (H_ACTIVE),
    .SEG_FRONT  (H_FP),
    .SEG_SYNC   (H_SYNC),
    .SEG_BACK   (H_BP),
    .CNT_W      (12)
  ) u_h_axis (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (!enable),
    .inc_i    (1'b1),
    .cnt_o    (h_cnt),
    .wrap_o   (h_wrap),
    .region_o (h_region)
  );

  dvi_axis_counter #(
    .SEG_ACTIVE (V_ACTIVE),
    .SEG_FRONT  (V_FP),
    .SEG_SYNC   (V_SYNC),
    .SEG_BACK   (V_BP),
    .CNT_W      (11)
  ) u_v_axis (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (!enable),
    .inc_i    (h_wrap),
    .cnt_o    (v_cnt),
    .wrap_o   (v_wrap),
    .region_o (v_region)
  );

  // Stage 1 (request) state.
  logic        pix_req_q, pix_req_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        frame_start_q, frame_start_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d;
  // High when the counters sit at (0,0); registered from the clear/frame wrap
  // so frame_start needs no wide zero compare on both counters.
  logic        origin_q, origin_d;
  logic        h_act, v_act;

  // Stage 2 (data return) state.
  logic        de2_q, hs2_q, vs2_q;

  // Stage 3 (encoder-facing) state.
  logic        disp_en_q;
  logic [23:0] rgb_q, rgb_d, src_rgb;
  dvi_ctrl_t   ctrl_q, ctrl_d;

  // Request decode from the live counters.
  always_comb begin
    h_act         = (h_cnt < H_ACT_END);
    v_act         = (v_cnt < V_ACT_END);
    pix_req_d     = enable && h_act && v_act;
    x_d           = pix_req_d ? h_cnt[10:0] : '0;
    y_d           = pix_req_d ? v_cnt : '0;
    frame_start_d = enable && origin_q;
    hs1_d         = enable && (h_region == SYNC);
    vs1_d         = enable && (v_region == SYNC);
    origin_d      = !enable || v_wrap;
  end

  // Stage 1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_req_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      origin_q      <= 1'b1;
    end else begin
      pix_req_q     <= pix_req_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      origin_q      <= origin_d;
    end
  end

  // Stage 2 registers: delay timing to line up with the returned pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de2_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
    end else begin
      de2_q <= pix_req_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

`ifdef DVI_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACTIVE / NUM_BARS > 0) ? H_ACTIVE / NUM_BARS : 1;

  logic [23:0] pat2_q, pat2_d;
  int unsigned bar_idx;

  // Bar colour for the requested column; clamps any remainder to the last bar.
  always_comb begin
    bar_idx = int unsigned'(x_q) / BAR_W;
    pat2_d  = bar_rgb((bar_idx > NUM_BARS - 1) ? 3'd7 : 3'(bar_idx));
  end

  // Pattern colour travels alongside the stage-2 timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat2_q <= '0;
    end else begin
      pat2_q <= pat2_d;
    end
  end
`endif

  // Output data select, blanking and sync polarity.
  always_comb begin
    src_rgb = pix_rgb;
`ifdef DVI_TEST_PATTERN_EN
    if (pattern_sel) begin
      src_rgb = pat2_q;
    end
`endif
    rgb_d  = de2_q ? src_rgb : '0;
    ctrl_d = {vs2_q ^ ~VSYNC_POL, hs2_q ^ ~HSYNC_POL};
  end

  // Stage 3 registers driving the encoders.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_en_q <= 1'b0;
      rgb_q     <= '0;
      ctrl_q    <= CTRL_IDLE;
    end else begin
      disp_en_q <= de2_q;
      rgb_q     <= rgb_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign pix_req     = pix_req_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign disp_en     = disp_en_q;
  assign red         = rgb_q[23:16];
  assign grn         = rgb_q[15:8];
  assign blu         = rgb_q[7:0];
  assign ctrl_b      = ctrl_q;

endmodule

// File: doc/dvi_timing_ctrl.md
DVI_TIMING_CTRL -- requirements
Module: dvi_timing_ctrl

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning), one per line:
  H_ACTIVE  640  visible pixels per line
  H_FP  16  horizontal front porch, clocks
  H_SYNC  96  hsync width, clocks
  H_BP  48  horizontal back porch, clocks
  V_ACTIVE  480  visible lines per frame
  V_FP  10  vertical front porch, lines
  V_SYNC  2  vsync width, lines
  V_BP  33  vertical back porch, lines
  HSYNC_POL  0  asserted hsync level
  VSYNC_POL  0  asserted vsync level
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
  clk  in  1  pixel clock; the single clock
  rst_n  in  1  asynchronous active-low reset
  enable  in  1  run timing; low forces blanking
  pix_req  out  1  pixel fetch request for (x,y)
  x  out  11  requested pixel column
  y  out  11  requested pixel row
  frame_start  out  1  one-cycle pulse with the request for (0,0)
  pix_rgb  in  24  {r,g,b} returned exactly one cycle after pix_req
  disp_en  out  1  active video, to all three encoders
  ctrl_b  out  2  {vsync,hsync} levels to the blue encoder
  red  out  8  red encoder data
  grn  out  8  green encoder data
  blu  out  8  blue encoder data

Function
REQ-003 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP) and wrap to 0; v_cnt SHALL increment on each h wrap, counting 0..V_TOTAL-1, and wrap to 0.
REQ-004 Region order on each axis SHALL be active, front porch, sync, back porch; hsync SHALL be asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync SHALL use the same rule on v_cnt.
REQ-005 pix_req, x and y SHALL be registered from the counters in cycle n; pix_req=1 only when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; x and y SHALL be 0 when pix_req=0.
REQ-006 pix_rgb SHALL be sampled in cycle n+1; disp_en, red, grn, blu and ctrl_b SHALL be registered and valid in cycle n+2, so sync and data stay aligned (total latency 2 clocks from request).
REQ-007 When disp_en=0, red/grn/blu SHALL be 0, and ctrl_b SHALL carry the delayed sync levels, with polarity applied as {vsync^~VSYNC_POL, hsync^~HSYNC_POL} for asserted syncs.
REQ-008 frame_start SHALL pulse only with pix_req for h_cnt=0 and v_cnt=0.
REQ-009 While enable=0, counters SHALL hold at 0, pix_req=0, disp_en=0 and ctrl_b SHALL be the deasserted sync levels; the pipeline SHALL still flush.
REQ-010 enable falling mid-frame SHALL zero the counters on the next edge; enable rising SHALL start a fresh frame at (0,0), with frame_start one cycle later.
REQ-011 Elaboration SHALL fail if H_TOTAL>4096, V_TOTAL>2048, or any parameter is 0.

Reset
REQ-012 Asserting rst_n=0 SHALL asynchronously clear the counters and pipeline; pix_req, x, y, frame_start, disp_en, red, grn and blu SHALL be 0, and ctrl_b SHALL be {~VSYNC_POL, ~HSYNC_POL}.
REQ-013 After reset release with enable=1, the first pix_req for (0,0) SHALL appear on the 1st rising edge.

Configuration
REQ-014 Macro DVI_TEST_PATTERN_EN SHALL add input port pattern_sel (1 bit).
REQ-015 With DVI_TEST_PATTERN_EN defined and pattern_sel=1, active data SHALL be 8 vertical colour bars, each H_ACTIVE/8 wide, in this order: white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF or 8'h00). pix_rgb SHALL be ignored and pix_req SHALL still toggle as normal.
REQ-016 Without DVI_TEST_PATTERN_EN, the port and pattern logic SHALL be absent and data SHALL always come from pix_rgb.

Structure
REQ-017 Package dvi_pkg SHALL hold the region enum (ACTIVE, FRONT, SYNC, BACK), the colour-bar constants and the 2-bit ctrl typedef shared with the TMDS encoders.
REQ-018 One sub-module, dvi_axis_counter, SHALL be instantiated twice (h and v). It SHALL provide the count, wrap pulse and region outputs, with a parameterised segment length.

Verification
REQ-019 Reset then enable=1, default params: first pix_req at (0,0) with frame_start=1; disp_en=1 with red/grn/blu equal to pix_rgb exactly 2 clocks after each request.
REQ-020 Count one full frame: exactly 800x525=420000 clocks between frame_start pulses, 307200 disp_en cycles, and 525 hsync pulses of 96 clocks each.
REQ-021 Check vsync: asserted (ctrl_b[1]=0) for exactly 2 lines (1600 clocks), starting at v_cnt=490, h_cnt=0.
REQ-022 Drop enable at x=100, y=200: next edge pix_req=0; disp_en=0 after 2 clocks; re-enable gives (0,0) with frame_start.
REQ-023 Assert rst_n=0 asynchronously mid-line: outputs reach reset values before the next clock edge.
REQ-024 With DVI_TEST_PATTERN_EN and pattern_sel=1: pixel x=80 gives {FF,FF,00}, x=639 gives {00,00,00}.
